// File: rtl/pulse_tx_job_sequencer.sv
// Job sequencer for the pulse transmitter: queues frame descriptors and walks the
// transmitter through them with a clean start edge, completion detect and inter-frame gap.
module pulse_tx_job_sequencer #(
    parameter int DEPTH         = 4,
    parameter int GAP_WIDTH     = 16,
    parameter int START_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [6:0]                 job_end_index,
    input  logic [6:0]                 job_loopback_index,
    input  logic [7:0]                 job_loop_count,
    input  logic [GAP_WIDTH-1:0]       job_gap,
    input  logic                       abort,
    input  logic                       irq_clear,
    output logic                       tx_start,
    output logic [6:0]                 tx_end_index,
    output logic [6:0]                 tx_loopback_index,
    output logic [7:0]                 tx_loop_count,
    input  logic                       tx_active,
    output logic                       job_done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       start_err,
    output logic                       irq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(START_TIMEOUT + 1);
    localparam int JOB_W = 22 + GAP_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_GAP
    } state_t;

    state_t               state;
    logic [JOB_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [JOB_W-1:0]     head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic [GAP_WIDTH-1:0] cur_gap;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [TMO_W-1:0]     tmo_cnt;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_W'(DEPTH));
    // A concurrent push during abort is refused so the flush leaves the queue truly empty.
    assign job_ready  = !fifo_full && !abort;
    assign push       = job_valid && job_ready;
    assign pop        = (state == S_IDLE) && !fifo_empty && !abort;
    assign head       = mem[rd_ptr];
    assign busy       = (state != S_IDLE);
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {job_end_index, job_loopback_index, job_loop_count, job_gap};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            tx_start          <= 1'b0;
            tx_end_index      <= '0;
            tx_loopback_index <= '0;
            tx_loop_count     <= '0;
            cur_gap           <= '0;
            gap_cnt           <= '0;
            tmo_cnt           <= '0;
            job_done          <= 1'b0;
            start_err         <= 1'b0;
            irq               <= 1'b0;
        end else begin
            job_done <= 1'b0;
            // Clear first so a set later in this block wins over a simultaneous clear.
            if (irq_clear) begin
                irq       <= 1'b0;
                start_err <= 1'b0;
            end
            if (abort) begin
                state    <= S_IDLE;
                tx_start <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        tx_start <= 1'b0;
                        if (pop) begin
                            tx_end_index      <= head[JOB_W-1 -: 7];
                            tx_loopback_index <= head[JOB_W-8 -: 7];
                            tx_loop_count     <= head[GAP_WIDTH+7 -: 8];
                            cur_gap           <= head[GAP_WIDTH-1:0];
                            state             <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        tx_start <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= S_START;
                    end
                    S_START: begin
                        if (tx_active) begin
                            state <= S_RUN;
                        end else if (tmo_cnt == TMO_W'(START_TIMEOUT - 1)) begin
                            start_err <= 1'b1;
                            tx_start  <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (!tx_active) begin
                            job_done <= 1'b1;
                            tx_start <= 1'b0;
                            if (fifo_empty) begin
                                irq <= 1'b1;
                            end
                            if (cur_gap == '0) begin
                                state <= S_IDLE;
                            end else begin
                                gap_cnt <= cur_gap;
                                state   <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        tx_start <= 1'b0;
                        if (gap_cnt == GAP_WIDTH'(1)) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                        end
                    end
                    default: begin
                        tx_start <= 1'b0;
                        state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_tx_job_sequencer.sv
// Directed bench for pulse_tx_job_sequencer with a small transmitter model that raises
// tx_active 3 cycles after tx_start rises and holds it for 20 cycles.
module tb_pulse_tx_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [6:0]  job_end_index;
    logic [6:0]  job_loopback_index;
    logic [7:0]  job_loop_count;
    logic [15:0] job_gap;
    logic        abort;
    logic        irq_clear;
    logic        tx_start;
    logic [6:0]  tx_end_index;
    logic [6:0]  tx_loopback_index;
    logic [7:0]  tx_loop_count;
    logic        tx_active;
    logic        job_done;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        start_err;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] hi_cnt = '0;
    logic       model_en = 1'b1;

    pulse_tx_job_sequencer #(.DEPTH(4), .GAP_WIDTH(16), .START_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_end_index(job_end_index), .job_loopback_index(job_loopback_index),
        .job_loop_count(job_loop_count), .job_gap(job_gap), .abort(abort),
        .irq_clear(irq_clear), .tx_start(tx_start), .tx_end_index(tx_end_index),
        .tx_loopback_index(tx_loopback_index), .tx_loop_count(tx_loop_count),
        .tx_active(tx_active), .job_done(job_done), .busy(busy),
        .fifo_level(fifo_level), .start_err(start_err), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) hi_cnt <= tx_start ? hi_cnt + 8'd1 : 8'd0;
    assign tx_active = model_en && tx_start && (hi_cnt >= 8'd3) && (hi_cnt < 8'd23);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [6:0] e, input logic [6:0] lb,
                            input logic [7:0] lc, input logic [15:0] g);
        job_valid = 1'b1; job_end_index = e; job_loopback_index = lb;
        job_loop_count = lc; job_gap = g;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic pulse_irq_clear();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; job_valid = 1'b0; abort = 1'b0; irq_clear = 1'b0;
        job_end_index = '0; job_loopback_index = '0; job_loop_count = '0; job_gap = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %0b want 1", job_ready); end
        n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %0b want 0", tx_start); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_tests++; if ({irq, start_err, job_done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {irq, start_err, job_done}); end
        n_tests++; if ({tx_end_index, tx_loopback_index, tx_loop_count} !== 22'd0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {tx_end_index, tx_loopback_index, tx_loop_count}); end
    endtask

    task automatic test_single_job();
        int dn = 0;
        int hi = 0;
        push_job(7'd5, 7'd0, 8'd1, 16'd0);
        n_tests++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", fifo_level); end
        n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_c1: got %0b want 0", tx_start); end
        tick();
        n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_load: got %0b want 0", tx_start); end
        n_tests++; if (tx_end_index !== 7'd5) begin n_fail++; $display("FAIL single_end_index: got %0d want 5", tx_end_index); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b want 1", busy); end
        tick();
        n_tests++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start_rise: got %0b want 1", tx_start); end
        for (int i = 0; i < 60; i++) begin
            if (job_done) dn++;
            if (tx_start) hi++;
            tick();
        end
        n_tests++; if (dn != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", dn); end
        n_tests++; if (hi != 24) begin n_fail++; $display("FAIL single_start_width: got %0d want 24", hi); end
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %0b want 1", irq); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %0b want 0", busy); end
        pulse_irq_clear();
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_clear: got %0b want 0", irq); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_end [5] = '{7'd10, 7'd11, 7'd12, 7'd13, 7'd14};
        logic [7:0] exp_lc  [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        int k = 1;
        int low = 0;
        int dn = 0;
        logic prev;
        for (int i = 0; i < 5; i++) push_job(exp_end[i], 7'd1, exp_lc[i], 16'd0);
        n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL b2b_level_full: got %0d want 4", fifo_level); end
        n_tests++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %0b want 0", job_ready); end
        push_job(7'd99, 7'd0, 8'd9, 16'd0);
        n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL b2b_level_after_refused: got %0d want 4", fifo_level); end
        n_tests++; if (tx_end_index !== 7'd10) begin n_fail++; $display("FAIL b2b_first_index: got %0d want 10", tx_end_index); end
        prev = tx_start;
        for (int i = 0; i < 200; i++) begin
            if (job_done) dn++;
            if (tx_start && !prev) begin
                if (k < 5) begin
                    n_tests++; if (tx_end_index !== exp_end[k]) begin n_fail++; $display("FAIL b2b_order_%0d: got %0d want %0d", k, tx_end_index, exp_end[k]); end
                    n_tests++; if (tx_loop_count !== exp_lc[k]) begin n_fail++; $display("FAIL b2b_loop_count_%0d: got %0d want %0d", k, tx_loop_count, exp_lc[k]); end
                    n_tests++; if (low != 2) begin n_fail++; $display("FAIL b2b_low_gap_%0d: got %0d want 2", k, low); end
                end
                k++;
                low = 0;
            end
            if (!tx_start) low++;
            prev = tx_start;
            tick();
        end
        n_tests++; if (k != 5) begin n_fail++; $display("FAIL b2b_frames: got %0d want 5", k); end
        n_tests++; if (dn != 5) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 5", dn); end
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL b2b_irq: got %0b want 1", irq); end
        pulse_irq_clear();
    endtask

    task automatic test_gap();
        int rises = 0;
        int low = 0;
        int dn = 0;
        logic prev;
        push_job(7'd20, 7'd2, 8'd1, 16'd10);
        push_job(7'd21, 7'd3, 8'd1, 16'd0);
        prev = tx_start;
        for (int i = 0; i < 150; i++) begin
            if (job_done) begin
                dn++;
                if (dn == 1) begin
                    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL gap_irq_early: got %0b want 0", irq); end
                end else begin
                    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL gap_irq_last: got %0b want 1", irq); end
                end
            end
            if (tx_start && !prev) begin
                rises++;
                if (rises == 2) begin
                    n_tests++; if (low != 12) begin n_fail++; $display("FAIL gap_low_time: got %0d want 12", low); end
                    n_tests++; if (tx_end_index !== 7'd21) begin n_fail++; $display("FAIL gap_second_index: got %0d want 21", tx_end_index); end
                end
                low = 0;
            end
            if (!tx_start) low++;
            prev = tx_start;
            tick();
        end
        n_tests++; if (dn != 2) begin n_fail++; $display("FAIL gap_done_count: got %0d want 2", dn); end
        pulse_irq_clear();
    endtask

    task automatic test_start_timeout();
        int hi = 0;
        int dn = 0;
        model_en = 1'b0;
        push_job(7'd50, 7'd0, 8'd1, 16'd0);
        for (int i = 0; i < 40; i++) begin
            if (tx_start) hi++;
            if (job_done) dn++;
            tick();
        end
        n_tests++; if (hi != 15) begin n_fail++; $display("FAIL timeout_start_width: got %0d want 15", hi); end
        n_tests++; if (dn != 0) begin n_fail++; $display("FAIL timeout_done: got %0d want 0", dn); end
        n_tests++; if (start_err !== 1'b1) begin n_fail++; $display("FAIL timeout_start_err: got %0b want 1", start_err); end
        n_tests++; if ({tx_start, busy, irq} !== 3'b000) begin n_fail++; $display("FAIL timeout_idle: got %b want 000", {tx_start, busy, irq}); end
        pulse_irq_clear();
        n_tests++; if (start_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %0b want 0", start_err); end
        model_en = 1'b1;
    endtask

    task automatic test_abort();
        int bad = 0;
        bit seen = 0;
        push_job(7'd30, 7'd0, 8'd1, 16'd0);
        push_job(7'd31, 7'd0, 8'd1, 16'd0);
        push_job(7'd32, 7'd0, 8'd1, 16'd0);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (tx_active) seen = 1;
            else tick();
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL abort_wait_active: got 0 want 1"); end
        repeat (2) tick();
        n_tests++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL abort_level_before: got %0d want 2", fifo_level); end
        abort = 1'b1; job_valid = 1'b1; job_end_index = 7'd40;
        #1;
        n_tests++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %0b want 0", job_ready); end
        tick();
        abort = 1'b0; job_valid = 1'b0;
        n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL abort_tx_start: got %0b want 0", tx_start); end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL abort_level: got %0d want 0", fifo_level); end
        n_tests++; if ({busy, job_done} !== 2'b00) begin n_fail++; $display("FAIL abort_busy_done: got %b want 00", {busy, job_done}); end
        for (int i = 0; i < 30; i++) begin
            if (job_done || tx_start) bad++;
            tick();
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d want 0", bad); end
        n_tests++; if (tx_end_index !== 7'd30) begin n_fail++; $display("FAIL abort_fields_held: got %0d want 30", tx_end_index); end
    endtask

    task automatic test_irq_clear_race();
        bit found = 0;
        pulse_irq_clear();
        push_job(7'd60, 7'd0, 8'd1, 16'd0);
        for (int i = 0; i < 100 && !found; i++) begin
            if (tx_start && !tx_active && hi_cnt >= 8'd3) found = 1;
            else tick();
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL race_wait_end: got 0 want 1"); end
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        n_tests++; if (job_done !== 1'b1) begin n_fail++; $display("FAIL race_job_done: got %0b want 1", job_done); end
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL race_irq_set_wins: got %0b want 1", irq); end
        pulse_irq_clear();
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL race_irq_clear_after: got %0b want 0", irq); end
    endtask

    task automatic test_reset_midframe();
        bit found = 0;
        push_job(7'd70, 7'd4, 8'd7, 16'd5);
        push_job(7'd71, 7'd4, 8'd7, 16'd5);
        for (int i = 0; i < 20 && !found; i++) begin
            if (tx_start) found = 1;
            else tick();
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rstmid_wait_start: got 0 want 1"); end
        rst_n = 1'b0;
        tick();
        n_tests++; if ({tx_start, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle: got %b want 00", {tx_start, busy}); end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
        n_tests++; if (tx_end_index !== 7'd0) begin n_fail++; $display("FAIL rstmid_fields: got %0d want 0", tx_end_index); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_back_to_back();
        test_gap();
        test_start_timeout();
        test_abort();
        test_irq_clear_race();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
